// File: rtl/score_accumulator.sv
// Queues coin and distance score requests and folds them into a 6-digit BCD score, one digit per cycle.
// Latency: a request sampled at edge T is granted at T+1 and committed at T+7; one add per 7 cycles.
// No backpressure: pending coins saturate (extra pulses dropped), a second distance tick while one is pending is dropped.
// Optional high-score tracking is built only when SCORE_HIGH_EN is defined; otherwise high_bcd is tied to zero.
module score_accumulator #(
  parameter int COIN_POINTS = 50,
  parameter int PEND_W      = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        game_active,
  input  logic        frame_done,
  input  logic [3:0]  speed,
  input  logic        coin_collected,
  output logic [23:0] score_bcd,
  output logic [23:0] high_bcd,
  output logic        busy,
  output logic        overflow
);

  // A coin worth more than two BCD digits cannot be represented by the addend.
  if ((COIN_POINTS < 0) || (COIN_POINTS > 99)) begin : g_bad_coin_points
    $error("score_accumulator: COIN_POINTS must be in 0..99");
  end

  localparam logic [3:0]        COIN_TENS = 4'(COIN_POINTS / 10);
  localparam logic [3:0]        COIN_ONES = 4'(COIN_POINTS % 10);
  localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};

  typedef enum logic {IDLE, ADD} state_t;

  state_t            state, state_nxt;
  logic [PEND_W-1:0] coin_pend;
  logic              dist_req;
  logic [7:0]        dist_amt;
  logic [7:0]        add_amt;
  logic [23:0]       work, work_nxt;
  logic [2:0]        dig_idx;
  logic              carry, carry_nxt;
  logic [23:0]       score_q;
  logic              overflow_q;

  logic              capture, coin_inc, dist_set;
  logic              grant_coin, grant_dist, discard, last_dig;
  logic              commit_vld;
  logic [23:0]       commit_val;
  logic [7:0]        speed_bcd;
  logic [3:0]        cur_dig, add_dig, new_dig;
  logic [4:0]        dig_sum;

  assign capture    = game_active & ~clear;
  assign coin_inc   = capture & coin_collected & (coin_pend != PEND_MAX);
  assign dist_set   = capture & frame_done & (speed != 4'd0) & ~dist_req;
  assign grant_coin = (state == IDLE) & ~overflow_q & (coin_pend != '0);
  assign grant_dist = (state == IDLE) & ~overflow_q & (coin_pend == '0) & dist_req;
  assign discard    = (state == IDLE) & overflow_q;
  assign last_dig   = (state == ADD) & (dig_idx == 3'd5);
  assign commit_vld = last_dig & ~clear;
  assign commit_val = carry_nxt ? 24'h999999 : work_nxt;

  assign score_bcd = score_q;
  assign overflow  = overflow_q;
  assign busy      = (state == ADD) | (coin_pend != '0) | dist_req;

  // Binary speed (0..15) converted to a two-digit BCD addend.
  always_comb begin
    speed_bcd = {4'd0, speed};
    if (speed >= 4'd10) speed_bcd = {4'd1, speed - 4'd10};
  end

  // One BCD digit of the serial add: select digit, add with carry, write back.
  always_comb begin
    cur_dig = 4'd0;
    for (int i = 0; i < 6; i++) begin
      if (dig_idx == 3'(i)) cur_dig = work[i*4 +: 4];
    end
    add_dig = 4'd0;
    if (dig_idx == 3'd0) add_dig = add_amt[3:0];
    if (dig_idx == 3'd1) add_dig = add_amt[7:4];
    dig_sum   = 5'(cur_dig) + 5'(add_dig) + 5'(carry);
    carry_nxt = 1'b0;
    new_dig   = dig_sum[3:0];
    if (dig_sum > 5'd9) begin
      carry_nxt = 1'b1;
      new_dig   = 4'(dig_sum - 5'd10);
    end
    work_nxt = work;
    for (int i = 0; i < 6; i++) begin
      if (dig_idx == 3'(i)) work_nxt[i*4 +: 4] = new_dig;
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: leave IDLE when any request is pending, return after digit 5; clear aborts.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (!overflow_q && ((coin_pend != '0) || dist_req)) state_nxt = ADD;
      ADD:  if (dig_idx == 3'd5) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  // Request queues, serial-add datapath and score commit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      coin_pend  <= '0;
      dist_req   <= 1'b0;
      dist_amt   <= 8'h00;
      add_amt    <= 8'h00;
      work       <= 24'h0;
      dig_idx    <= 3'd0;
      carry      <= 1'b0;
      score_q    <= 24'h0;
      overflow_q <= 1'b0;
    end else if (clear) begin
      coin_pend  <= '0;
      dist_req   <= 1'b0;
      work       <= 24'h0;
      dig_idx    <= 3'd0;
      carry      <= 1'b0;
      score_q    <= 24'h0;
      overflow_q <= 1'b0;
    end else begin
      // Increment and grant on the same edge cancel out.
      if (discard)                    coin_pend <= '0;
      else if (coin_inc && !grant_coin) coin_pend <= coin_pend + 1'b1;
      else if (!coin_inc && grant_coin) coin_pend <= coin_pend - 1'b1;

      if (discard || grant_dist) begin
        dist_req <= 1'b0;
      end else if (dist_set) begin
        dist_req <= 1'b1;
        dist_amt <= speed_bcd;
      end

      if (grant_coin || grant_dist) begin
        work    <= score_q;
        add_amt <= grant_coin ? {COIN_TENS, COIN_ONES} : dist_amt;
        dig_idx <= 3'd0;
        carry   <= 1'b0;
      end else if (state == ADD) begin
        work    <= work_nxt;
        carry   <= carry_nxt;
        dig_idx <= dig_idx + 3'd1;
      end

      if (commit_vld) begin
        score_q <= commit_val;
        if (carry_nxt) overflow_q <= 1'b1;
      end
    end
  end

`ifdef SCORE_HIGH_EN
  logic [23:0] high_q;

  // Best committed score; survives clear, only reset zeroes it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                 high_q <= 24'h0;
    else if (commit_vld && (commit_val > high_q)) high_q <= commit_val;
  end

  assign high_bcd = high_q;
`else
  assign high_bcd = 24'h0;
`endif

endmodule

// File: tb/tb_score_accumulator.sv
// Directed bench for score_accumulator: vector table plus hand-written latency/corner sequences.
// Inputs are driven and outputs sampled on the falling clock edge.
// Expected values are hand-computed BCD constants.
module tb_score_accumulator;

  logic        clock = 1'b0;
  logic        reset;
  logic        clear;
  logic        game_active;
  logic        frame_done;
  logic [3:0]  speed;
  logic        coin_collected;
  logic [23:0] score_bcd;
  logic [23:0] high_bcd;
  logic        busy;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  score_accumulator #(.COIN_POINTS(50), .PEND_W(3)) dut (
    .clock          (clock),
    .reset          (reset),
    .clear          (clear),
    .game_active    (game_active),
    .frame_done     (frame_done),
    .speed          (speed),
    .coin_collected (coin_collected),
    .score_bcd      (score_bcd),
    .high_bcd       (high_bcd),
    .busy           (busy),
    .overflow       (overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        ga;
    logic        coin;
    logic [3:0]  spd;
    logic [23:0] exp_score;
  } vec_t;

  vec_t vecs[10];

  task automatic nclk();
    @(negedge clock);
  endtask

  task automatic check(input string nm, input logic [23:0] act, input logic [23:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  task automatic wait_idle(input string nm);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (!busy) done = 1'b1;
      else nclk();
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s: busy still %b after cycle budget, expected 0", nm, busy);
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    nclk();
    clear = 1'b0;
  endtask

  task automatic coin_pulse();
    coin_collected = 1'b1;
    nclk();
    coin_collected = 1'b0;
  endtask

  initial begin
    logic [23:0] exp_high;
    `ifdef SCORE_HIGH_EN
    exp_high = 24'h000100;
    `else
    exp_high = 24'h000000;
    `endif

    vecs[0] = '{1'b1, 1'b1, 4'd0,  24'h000050};
    vecs[1] = '{1'b1, 1'b0, 4'd9,  24'h000059};
    vecs[2] = '{1'b1, 1'b0, 4'd15, 24'h000074};
    vecs[3] = '{1'b1, 1'b0, 4'd15, 24'h000089};
    vecs[4] = '{1'b1, 1'b0, 4'd6,  24'h000095};
    vecs[5] = '{1'b1, 1'b1, 4'd0,  24'h000145};
    vecs[6] = '{1'b1, 1'b1, 4'd13, 24'h000208};
    vecs[7] = '{1'b0, 1'b1, 4'd7,  24'h000208};
    vecs[8] = '{1'b1, 1'b0, 4'd0,  24'h000208};
    vecs[9] = '{1'b1, 1'b0, 4'd10, 24'h000218};

    reset = 1'b1; clear = 1'b0; game_active = 1'b0;
    frame_done = 1'b0; speed = 4'd0; coin_collected = 1'b0;
    nclk(); nclk();
    reset = 1'b0;
    nclk();
    check("reset_score", score_bcd, 24'h0);
    check("reset_high", high_bcd, 24'h0);
    check("reset_busy", {23'h0, busy}, 24'h0);
    check("reset_overflow", {23'h0, overflow}, 24'h0);
    game_active = 1'b1;

    // Game 1 scores 100, then a new game.
    coin_pulse();
    coin_pulse();
    wait_idle("game1_idle");
    check("game1_score", score_bcd, 24'h000100);
    do_clear();
    check("clear_score", score_bcd, 24'h0);
    check("high_after_clear", high_bcd, exp_high);

    // Single coin latency: pulse sampled at edge T.
    coin_collected = 1'b1;
    nclk();                               // after T
    coin_collected = 1'b0;
    check("single_busy_T", {23'h0, busy}, 24'h1);
    repeat (6) nclk();                    // after T+6
    check("single_no_partial", score_bcd, 24'h0);
    check("single_busy_T6", {23'h0, busy}, 24'h1);
    nclk();                               // after T+7
    check("single_commit", score_bcd, 24'h000050);
    check("single_busy_T7", {23'h0, busy}, 24'h0);
    check("high_game2", high_bcd, exp_high);

    // Three consecutive coins commit at T+7, T+14, T+21.
    do_clear();
    coin_collected = 1'b1;
    nclk(); nclk(); nclk();               // after T+2
    coin_collected = 1'b0;
    repeat (5) nclk();                    // after T+7
    check("b2b_first", score_bcd, 24'h000050);
    repeat (6) nclk();                    // after T+13
    check("b2b_hold", score_bcd, 24'h000050);
    nclk();                               // after T+14
    check("b2b_second", score_bcd, 24'h000100);
    repeat (7) nclk();                    // after T+21
    check("b2b_third", score_bcd, 24'h000150);
    check("b2b_busy", {23'h0, busy}, 24'h0);

    // Coin and distance on the same cycle: coin commits first.
    do_clear();
    coin_collected = 1'b1; frame_done = 1'b1; speed = 4'd13;
    nclk();                               // after T
    coin_collected = 1'b0; frame_done = 1'b0; speed = 4'd0;
    repeat (7) nclk();                    // after T+7
    check("simul_coin_first", score_bcd, 24'h000050);
    wait_idle("simul_idle");
    check("simul_total", score_bcd, 24'h000063);

    // Nine pulses: one granted immediately, seven queued, last dropped.
    do_clear();
    coin_collected = 1'b1;
    repeat (9) nclk();
    coin_collected = 1'b0;
    wait_idle("sat_idle");
    check("sat_score", score_bcd, 24'h000400);

    // Fresh reset then the vector table.
    reset = 1'b1;
    nclk();
    reset = 1'b0;
    check("reset2_high", high_bcd, 24'h0);
    check("reset2_score", score_bcd, 24'h0);
    for (int v = 0; v < 10; v++) begin
      game_active    = vecs[v].ga;
      coin_collected = vecs[v].coin;
      frame_done     = 1'b1;
      speed          = vecs[v].spd;
      nclk();
      game_active = 1'b1; coin_collected = 1'b0; frame_done = 1'b0; speed = 4'd0;
      wait_idle($sformatf("vec%0d_idle", v));
      check($sformatf("vec%0d_score", v), score_bcd, vecs[v].exp_score);
      check($sformatf("vec%0d_overflow", v), {23'h0, overflow}, 24'h0);
    end

    // Clear at edge T+4 of an add aborts it.
    coin_collected = 1'b1;
    nclk();                               // after T
    coin_collected = 1'b0;
    repeat (3) nclk();                    // after T+3
    clear = 1'b1;
    nclk();                               // after T+4
    clear = 1'b0;
    check("abort_score", score_bcd, 24'h0);
    check("abort_busy", {23'h0, busy}, 24'h0);
    check("abort_overflow", {23'h0, overflow}, 24'h0);
    repeat (10) nclk();
    check("abort_no_commit", score_bcd, 24'h0);

    // Overflow: preload 999990 into the score, add one coin.
    force dut.score_q = 24'h999990;
    coin_collected = 1'b1;
    nclk();                               // after T
    coin_collected = 1'b0;
    nclk();                               // after T+1, work loaded
    release dut.score_q;
    wait_idle("ovf_idle");
    check("ovf_score", score_bcd, 24'h999999);
    check("ovf_flag", {23'h0, overflow}, 24'h1);
    coin_collected = 1'b1; frame_done = 1'b1; speed = 4'd5;
    nclk(); nclk(); nclk();
    coin_collected = 1'b0; frame_done = 1'b0; speed = 4'd0;
    repeat (12) nclk();
    check("ovf_hold_score", score_bcd, 24'h999999);
    check("ovf_sticky", {23'h0, overflow}, 24'h1);
    check("ovf_discard_busy", {23'h0, busy}, 24'h0);
    do_clear();
    check("ovf_clear_flag", {23'h0, overflow}, 24'h0);
    check("ovf_clear_score", score_bcd, 24'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/score_accumulator.md
# score_accumulator

Consumer end of the coin-collection and distance-scoring path. It accepts one-cycle `coin_collected` pulses and per-frame distance ticks, queues them, and folds each into a 6-digit BCD score with a digit-serial adder FSM. When enabled, it also maintains a high-score register. `score_bcd` and `high_bcd` feed the HUD digit renderer directly.

## Interface
- `COIN_POINTS`, default 50: points per coin, legal range 0–99; split into tens and ones BCD digits at elaboration.
- `PEND_W`, default 3: width of the pending-coin counter; it saturates at 2^PEND_W−1.

- `clock`  in  1  system clock
- `reset`  in  1  asynchronous, active-high
- `clear`  in  1  synchronous new-game clear
- `game_active`  in  1  score sources are accepted only while high
- `frame_done`  in  1  one-cycle end-of-frame strobe
- `speed`  in  4  distance points for this frame (0–15)
- `coin_collected`  in  1  one-cycle collect pulse from the coin logic
- `score_bcd`  out  24  6 BCD digits; [3:0] is the ones digit
- `high_bcd`  out  24  best score since reset, BCD
- `busy`  out  1  an add is in flight or a request is pending
- `overflow`  out  1  sticky; set when the score has saturated at 999999

## Operation
- **Request capture** (while `game_active`=1 and `clear`=0):
  - `coin_collected`=1 increments `coin_pend`. At max the pulse is dropped.
  - `frame_done`=1 with `speed`≠0 sets `dist_req` and latches `dist_amt` = `speed` as BCD: tens = (`speed`≥10), ones = `speed` mod 10.
  - If `dist_req` is already set, the new tick is dropped and the old amount is kept.
- **FSM states:** IDLE, ADD.
- **IDLE:**
  - If `overflow`=1, all requests are discarded.
  - Else if `coin_pend`>0: addend = `COIN_POINTS`, decrement `coin_pend`, go to ADD.
  - Else if `dist_req`: addend = `dist_amt`, clear `dist_req`, go to ADD.
  - Coins have priority over distance.
  - An increment and a grant on the same edge leave `coin_pend` unchanged.
- **ADD:**
  - Process digit index i = 0..5, one per cycle: s = work[i] + add[i] + carry.
  - If s>9: work[i] = s−10, carry = 1. Otherwise work[i] = s, carry = 0.
  - add[i] = 0 for i ≥ 2.
  - `work` is loaded from `score_bcd` at grant.
  - After i=5, commit `work` to `score_bcd` and return to IDLE.
  - If carry out of digit 5 is 1, commit 0x999999 instead and set `overflow`.
- **`busy`** = (state==ADD) | (`coin_pend`≠0) | `dist_req`, decoded from registers.
- **`clear`** has highest priority. It zeroes `score_bcd`, `coin_pend`, `dist_req`, `overflow`, and `work`, and forces IDLE, aborting any in-flight add. `high_bcd` is retained.
- **Out-of-range `COIN_POINTS`:** values above 99 are an elaboration error.

## Timing
- **Reset values:** `score_bcd`=0, `high_bcd`=0, `busy`=0, `overflow`=0, state IDLE, `coin_pend`=0, `dist_req`=0.
- **Single add latency:**
  - Pulse sampled at edge T → `coin_pend`=1 after T.
  - Grant at edge T+1.
  - Digits 0..5 processed on edges T+2..T+7.
  - `score_bcd` updated after edge T+7.
- **Throughput:** one add per 7 cycles (1 IDLE + 6 ADD). The back-to-back grant occurs at the edge after commit.
- `score_bcd` never shows partial sums; it changes only at commit.
- `high_bcd` updates on the same edge as the commit it compares against.
- `frame_done` and `coin_collected` on the same cycle are both captured.

## Configuration
- **`SCORE_HIGH_EN` defined:** on every commit, if the committed value > `high_bcd` (unsigned 24-bit compare, which is valid for BCD), `high_bcd` takes the committed value. Only `reset` zeroes it.
- **`SCORE_HIGH_EN` undefined:** `high_bcd` is tied to 24'h0 and no compare logic is generated.

## Test plan
- **Single coin:** reset, `game_active`=1, one `coin_collected` pulse at edge T → `busy`=1 from T, `score_bcd`=24'h000050 exactly after edge T+7, `busy`=0 after T+7.
- **Back-to-back coins:** three `coin_collected` pulses on consecutive cycles → commits after edges T+7, T+14, T+21, reaching 24'h000150. Nine pulses with `PEND_W`=3 and no interleaved grants → at most 7+1 counted.
- **Simultaneous sources:** coin and `frame_done` with `speed`=13 on the same cycle → coin added first (0x000050), then distance, giving 24'h000063.
- **Carry ripple:** reach 0x000095 (one coin, then `speed`=9, 15, 15, 6), then one coin → 24'h000145. Reaching 0x999990 → next coin gives 24'h999999 with `overflow`=1, and subsequent pulses leave the score unchanged.
- **Clear mid-add:** assert `clear` at edge T+4 of an add → `score_bcd`=0, `busy`=0, `overflow`=0 after that edge, and the aborted add never commits.
- **High score (`SCORE_HIGH_EN`):** game scoring 0x000100, then `clear`, then game scoring 0x000050 → `high_bcd`=24'h000100 throughout game 2. With the macro undefined, `high_bcd`=0 always.
